// File: rtl/div5_word_serializer.sv
// -----------------------------------------------------------------------------
// div5_word_serializer
// Feeds parallel words, MSB first, one bit per clock, into a downstream serial
// divisibility-by-5 checker. Each word gets a one-cycle clear pulse before its
// bits are sent. One cycle after the last bit, the block samples the checker's
// q. It also compares that q against its own running remainder and flags any
// disagreement.
//
// Ports
//   clk           in   1      system clock, posedge
//   reset         in   1      asynchronous, active-high reset
//   word_in       in   WIDTH  word to test, captured on the accept cycle
//   word_valid    in   1      word_in is valid
//   word_ready    out  1      ready for a word (IDLE only)
//   ser_clear     out  1      one-cycle clear pulse to the checker
//   ser_bit       out  1      serial bit, MSB first
//   ser_valid     out  1      ser_bit carries a word bit
//   q_in          in   1      checker q (1 = bits so far divisible by 5)
//   result_valid  out  1      result_div5 / result_err are valid
//   result_ready  in   1      consumer takes the result
//   result_div5   out  1      word divisible by 5, as reported by the checker
//   result_err    out  1      checker q disagreed with the internal remainder
// -----------------------------------------------------------------------------
module div5_word_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             ser_clear,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             q_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_div5,
    output logic             result_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned REM_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic [REM_W-1:0]   r_rem;
    logic               r_div5;
    logic               r_err;

    logic               w_accept;
    logic               w_last_bit;
    logic [REM_W:0]     w_rem_sum;
    logic [REM_W-1:0]   w_rem_nxt;

    assign w_accept   = (r_state == S_IDLE) && word_valid;
    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    // 2*rem + bit is at most 9, so one conditional subtract reduces it mod 5
    assign w_rem_sum = {r_rem, r_shreg[WIDTH-1]};
    assign w_rem_nxt = (w_rem_sum >= 4'd5) ? REM_W'(w_rem_sum - 4'd5)
                                           : w_rem_sum[REM_W-1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (word_valid) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_DONE;
            S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state and registered datapath only
    always_comb begin
        word_ready   = 1'b0;
        ser_clear    = 1'b0;
        ser_bit      = 1'b0;
        ser_valid    = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_IDLE:  word_ready   = 1'b1;
            S_CLEAR: ser_clear    = 1'b1;
            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = r_shreg[WIDTH-1];
            end
            S_DONE:  result_valid = 1'b1;
            default: ;
        endcase
    end

    assign result_div5 = r_div5;
    assign result_err  = r_err;

    // Shift register, bit counter and running remainder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
        end else if (w_accept) begin
            r_shreg <= word_in;
            r_cnt   <= '0;
            r_rem   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + CNT_W'(1);
            r_rem   <= w_rem_nxt;
        end
    end

    // Result capture: q_in is only meaningful in WAIT, after all bits are in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div5 <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_div5 <= q_in;
            r_err  <= (q_in != (r_rem == '0));
        end
    end

endmodule

// File: tb/tb_div5_word_serializer.sv
module tb_div5_word_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         ser_clear;
    logic         ser_bit;
    logic         ser_valid;
    logic         q_in;
    logic         result_valid;
    logic         result_ready;
    logic         result_div5;
    logic         result_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic       force_q0;
    logic [2:0] chk_rem;
    logic [1:0] res_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div5_word_serializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .ser_clear   (ser_clear),
        .ser_bit     (ser_bit),
        .ser_valid   (ser_valid),
        .q_in        (q_in),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_div5 (result_div5),
        .result_err  (result_err)
    );

    // Downstream checker: Moore FSM over remainder classes, synchronous clear
    always @(posedge clk or posedge reset) begin
        if (reset) chk_rem <= 3'd0;
        else if (ser_clear) chk_rem <= 3'd0;
        else begin
            case (chk_rem)
                3'd0: chk_rem <= ser_bit ? 3'd1 : 3'd0;
                3'd1: chk_rem <= ser_bit ? 3'd3 : 3'd2;
                3'd2: chk_rem <= ser_bit ? 3'd0 : 3'd4;
                3'd3: chk_rem <= ser_bit ? 3'd2 : 3'd1;
                3'd4: chk_rem <= ser_bit ? 3'd4 : 3'd3;
                default: chk_rem <= 3'd0;
            endcase
        end
    end
    assign q_in = force_q0 ? 1'b0 : (chk_rem == 3'd0);

    // Collect results as they are handed off
    always @(negedge clk) begin
        if (!reset && result_valid && result_ready)
            res_q.push_back({result_div5, result_err});
    end

    typedef struct {
        logic [7:0] word;
        logic       div5;
        logic       err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] out_vec();
        return {word_ready, ser_clear, ser_bit, ser_valid, result_valid, result_div5, result_err};
    endfunction

    // One full word with result_ready high; checks timing, stream and result
    task automatic run_word(input logic [7:0] w, input logic exp_div5, input logic exp_err);
        logic [7:0] stream;
        int         nvalid;
        int         n;
        stream = '0;
        nvalid = 0;
        n      = 0;
        while (!word_ready && n < 40) begin
            step();
            n++;
        end
        check($sformatf("ready_%02h", w), 32'(word_ready), 32'd1);
        word_in    = w;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        word_in    = 8'($urandom);
        check($sformatf("clear_pulse_%02h", w), 32'({ser_clear, ser_valid}), 32'b10);
        for (int i = 0; i < 8; i++) begin
            step();
            stream = {stream[6:0], ser_bit};
            if (ser_valid) nvalid++;
        end
        check($sformatf("stream_%02h", w), 32'(stream), 32'(w));
        check($sformatf("ser_valid_cnt_%02h", w), 32'(nvalid), 32'd8);
        step();
        check($sformatf("no_result_c10_%02h", w), 32'(result_valid), 32'd0);
        step();
        check($sformatf("result_valid_c11_%02h", w), 32'(result_valid), 32'd1);
        check($sformatf("div5_%02h", w), 32'(result_div5), 32'(exp_div5));
        check($sformatf("err_%02h", w), 32'(result_err), 32'(exp_err));
        step();
        check($sformatf("idle_after_%02h", w), 32'({word_ready, result_valid}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        int n;
        logic rb;
        logic stable;

        vecs[0] = '{8'h0A, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'hC8, 1'b1, 1'b0};
        vecs[5] = '{8'h7B, 1'b0, 1'b0};

        reset        = 1'b1;
        word_in      = '0;
        word_valid   = 1'b0;
        result_ready = 1'b1;
        force_q0     = 1'b0;
        step();
        step();
        check("reset_outputs", 32'(out_vec()), 32'b1000000);
        reset = 1'b0;
        step();
        check("idle_after_reset", 32'(out_vec()), 32'b1000000);

        for (int i = 0; i < 6; i++)
            run_word(vecs[i].word, vecs[i].div5, vecs[i].err);

        // Back-to-back 0x0F then 0x10 with word_valid held high
        res_q.delete();
        word_in    = 8'h0F;
        word_valid = 1'b1;
        step();
        a0      = cyc;
        a1      = -1;
        word_in = 8'h10;
        for (int i = 0; i < 30; i++) begin
            rb = word_ready;
            step();
            if (rb) begin
                a1 = cyc;
                break;
            end
        end
        word_valid = 1'b0;
        check("b2b_spacing", 32'(a1 - a0), 32'd12);
        n = 0;
        while (res_q.size() < 2 && n < 40) begin
            step();
            n++;
        end
        check("b2b_count", 32'(res_q.size()), 32'd2);
        check("b2b_first_0F", 32'(res_q[0]), 32'b10);
        check("b2b_second_10", 32'(res_q[1]), 32'b00);

        // Result backpressure for 20 cycles
        result_ready = 1'b0;
        word_in      = 8'h14;
        word_valid   = 1'b1;
        step();
        word_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin
            step();
            n++;
        end
        check("stall_result_valid", 32'(result_valid), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!(result_valid && result_div5 && !result_err && !word_ready)) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        result_ready = 1'b1;
        step();
        check("stall_release_idle", 32'({word_ready, result_valid}), 32'b10);

        // Reset while shifting 0x55, after 3 bits
        word_in    = 8'h55;
        word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_in_shift", 32'({ser_valid, word_ready}), 32'b10);
        reset = 1'b1;
        #1;
        check("abort_reset_outputs", 32'(out_vec()), 32'b1000000);
        step();
        check("abort_held", 32'(out_vec()), 32'b1000000);
        reset = 1'b0;
        step();
        run_word(8'h19, 1'b1, 1'b0);

        // Lying checker: q forced 0 for a word that is divisible by 5
        force_q0 = 1'b1;
        run_word(8'h05, 1'b0, 1'b1);
        force_q0 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
